// File: rtl/bus_master_fsm.sv
// bus_master_fsm: initiator side of the IO_bus register protocol.
// Takes one host read/write command at a time, drives the bus through a
// four-phase handshake (handshake_1 request / handshake_2 acknowledge),
// captures read data, and returns exactly one response per command.
// Every handshake wait is bounded; an expired wait returns an error response.
module bus_master_fsm #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] bus_reg_address,
  output logic                  bus_RW,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic                  bus_handshake_1,
  input  logic                  bus_handshake_2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_RELEASE,
    S_RESP
  } state_t;

  // The timer counts completed wait cycles in the current state; the wait
  // expires on the cycle that would make the count reach TIMEOUT_CYCLES.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [15:0]             timer_reg, timer_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    rw_reg, rw_next;
  logic [DATA_WIDTH-1:0]   dout_reg, dout_next;
  logic                    hs1_reg, hs1_next;
  logic [DATA_WIDTH-1:0]   cap_reg, cap_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic                    error_reg, error_next;
  logic                    timed_out;

  assign timed_out       = (timer_reg == TIMER_LAST);
  assign cmd_ready       = (state_reg == S_IDLE);
  assign rsp_valid       = (state_reg == S_RESP);
  assign rsp_rdata       = rdata_reg;
  assign rsp_error       = error_reg;
  assign bus_reg_address = addr_reg;
  assign bus_RW          = rw_reg;
  assign bus_data_out    = dout_reg;
  assign bus_handshake_1 = hs1_reg;

  // State and output registers; reset drops the request strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
      addr_reg  <= '0;
      rw_reg    <= 1'b0;
      dout_reg  <= '0;
      hs1_reg   <= 1'b0;
      cap_reg   <= '0;
      rdata_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      addr_reg  <= addr_next;
      rw_reg    <= rw_next;
      dout_reg  <= dout_next;
      hs1_reg   <= hs1_next;
      cap_reg   <= cap_next;
      rdata_reg <= rdata_next;
      error_reg <= error_next;
    end
  end

  // Next-state and next-output decode for the handshake sequence.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    addr_next  = addr_reg;
    rw_next    = rw_reg;
    dout_next  = dout_reg;
    hs1_next   = hs1_reg;
    cap_next   = cap_reg;
    rdata_next = rdata_reg;
    error_next = error_reg;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          // Bus fields are frozen here and held until the next accept.
          addr_next  = cmd_addr;
          rw_next    = cmd_rw;
          dout_next  = cmd_rw ? '0 : cmd_wdata;
          error_next = 1'b0;
          timer_next = '0;
          state_next = S_SETUP;
        end
      end

      S_SETUP: begin
        // A leftover acknowledge from an earlier aborted access must clear
        // before a new request may be raised.
        if (!bus_handshake_2) begin
          hs1_next   = 1'b1;
          timer_next = '0;
          state_next = S_REQ;
        end else if (timed_out) begin
          hs1_next   = 1'b0;
          rdata_next = '0;
          error_next = 1'b1;
          timer_next = '0;
          state_next = S_RESP;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      S_REQ: begin
        if (bus_handshake_2) begin
          // Read data is held privately so the previous response stays
          // visible on rsp_rdata until this access actually completes.
          if (rw_reg) begin
            cap_next = bus_data_in;
          end
          hs1_next   = 1'b0;
          timer_next = '0;
          state_next = S_RELEASE;
        end else if (timed_out) begin
          hs1_next   = 1'b0;
          rdata_next = '0;
          error_next = 1'b1;
          timer_next = '0;
          state_next = S_RESP;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      S_RELEASE: begin
        if (!bus_handshake_2) begin
          rdata_next = rw_reg ? cap_reg : '0;
          error_next = 1'b0;
          timer_next = '0;
          state_next = S_RESP;
        end else if (timed_out) begin
          rdata_next = '0;
          error_next = 1'b1;
          timer_next = '0;
          state_next = S_RESP;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      S_RESP: begin
        timer_next = '0;
        state_next = S_IDLE;
      end

      default: begin
        hs1_next   = 1'b0;
        timer_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_master_fsm.sv
// tb_bus_master_fsm: self-checking bench for bus_master_fsm.
// Two instances (long and short timeout) share stimulus; sel picks which one
// is exercised and observed. A behavioural responder acks with configurable
// delays; expected responses come from the protocol timing rules.
`timescale 1ns/1ps
module tb_bus_master_fsm;
  localparam int T_A = 255;
  localparam int T_B = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        hs2 = 1'b0;
  logic [31:0] data_in = 'z;
  logic        sel = 1'b0;

  logic        cv_a, cv_b;
  logic        rdy_a, rdy_b, rv_a, rv_b, err_a, err_b, rw_a, rw_b, hs1_a, hs1_b;
  logic [31:0] rd_a, rd_b, do_a, do_b;
  logic [7:0]  ad_a, ad_b;

  assign cv_a = cmd_valid & ~sel;
  assign cv_b = cmd_valid & sel;

  logic        rdy, rv, err, brw, hs1;
  logic [31:0] rd, dout;
  logic [7:0]  addr_o;
  assign rdy    = sel ? rdy_b : rdy_a;
  assign rv     = sel ? rv_b  : rv_a;
  assign err    = sel ? err_b : err_a;
  assign brw    = sel ? rw_b  : rw_a;
  assign hs1    = sel ? hs1_b : hs1_a;
  assign rd     = sel ? rd_b  : rd_a;
  assign dout   = sel ? do_b  : do_a;
  assign addr_o = sel ? ad_b  : ad_a;

  bus_master_fsm #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T_A)) dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cv_a), .cmd_ready(rdy_a), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_error(err_a),
    .bus_reg_address(ad_a), .bus_RW(rw_a), .bus_data_out(do_a), .bus_data_in(data_in),
    .bus_handshake_1(hs1_a), .bus_handshake_2(hs2)
  );

  bus_master_fsm #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T_B)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cv_b), .cmd_ready(rdy_b), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_error(err_b),
    .bus_reg_address(ad_b), .bus_RW(rw_b), .bus_data_out(do_b), .bus_data_in(data_in),
    .bus_handshake_1(hs1_b), .bus_handshake_2(hs2)
  );

  // Responder: registered subsystem that raises handshake_2 ack_d cycles after
  // it first sees handshake_1 high and drops it rel_d cycles after it sees it low.
  logic        mapped = 1'b1;
  int          ack_d = 1;
  int          rel_d = 1;
  logic [31:0] word = '0;
  int          hi_cnt = 0;
  int          lo_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (hs1 === 1'b1) begin hi_cnt++; lo_cnt = 0; end
    else begin lo_cnt++; hi_cnt = 0; end
    if (!reset) begin
      hs2 = 1'b0; data_in = 'z;
    end else if (!hs2 && hs1 === 1'b1 && mapped && hi_cnt == ack_d + 1) begin
      hs2 = 1'b1; data_in = word;
    end else if (hs2 && hs1 !== 1'b1 && lo_cnt >= rel_d + 1) begin
      hs2 = 1'b0; data_in = 'z;
    end
  end

  int checks = 0;
  int errors = 0;

  // Observations from the most recent transaction.
  logic [31:0] t_rdata;
  logic        t_err, t_bus_bad, t_rdy_bad, t_extra, t_done;
  int          t_lat, t_hs1;

  // Drives one command (called #1 after an edge with the DUT idle) and records
  // what the bus and response looked like; latency counts edges from accept.
  task automatic run_txn(input logic rw, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic hold);
    logic [31:0] exp_dout;
    exp_dout  = rw ? 32'h0 : wdata;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    t_lat = 0; t_hs1 = 0; t_bus_bad = 0; t_rdy_bad = 0; t_extra = 0; t_done = 0;
    t_rdata = '0; t_err = 1'b0;
    while (t_lat < 1000) begin
      if (addr_o !== addr || brw !== rw || dout !== exp_dout) t_bus_bad = 1'b1;
      if (rdy !== 1'b0) t_rdy_bad = 1'b1;
      if (hs1 === 1'b1) t_hs1++;
      if (rv === 1'b1) begin t_done = 1'b1; t_rdata = rd; t_err = err; break; end
      if (hold) begin cmd_addr = 8'($urandom); cmd_wdata = $urandom; end
      @(posedge clk); #1;
      t_lat++;
    end
    cmd_valid = 1'b0;
    if (t_done) begin
      @(posedge clk); #1;
      if (rv !== 1'b0) t_extra = 1'b1;
    end
    $display("txn dut=%0d rw=%0b addr=%02h wdata=%08h lat=%0d hs1=%0d rdata=%08h err=%0b",
             sel, rw, addr, wdata, t_lat, t_hs1, t_rdata, t_err);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdy_a, rv_a, err_a, hs1_a, rw_a} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl_a: got %05b want 10000", {rdy_a, rv_a, err_a, hs1_a, rw_a});
    end
    checks++;
    if ({ad_a, rd_a, do_a} !== 72'h0) begin
      errors++; $display("FAIL reset_data_a: got %018h want 0", {ad_a, rd_a, do_a});
    end
    checks++;
    if ({rdy_b, rv_b, err_b, hs1_b, rw_b, ad_b, rd_b, do_b} !== {5'b10000, 72'h0}) begin
      errors++; $display("FAIL reset_b: got %0b %018h want 10000 0", {rdy_b, rv_b, err_b, hs1_b, rw_b}, {ad_b, rd_b, do_b});
    end
  endtask

  task automatic test_write();
    sel = 1'b0; mapped = 1'b1; ack_d = 2; rel_d = 1; word = $urandom;
    run_txn(1'b0, 8'h01, 32'h0000_03E8, 1'b0);
    checks++; if (t_done !== 1'b1) begin errors++; $display("FAIL write_done: got %0b want 1", t_done); end
    checks++; if (t_lat != 6) begin errors++; $display("FAIL write_lat: got %0d want 6", t_lat); end
    checks++; if (t_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata: got %08h want 0", t_rdata); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL write_err: got %0b want 0", t_err); end
    checks++; if (t_bus_bad !== 1'b0) begin errors++; $display("FAIL write_bus_hold: got %0b want 0", t_bus_bad); end
    checks++; if (t_extra !== 1'b0) begin errors++; $display("FAIL write_pulse: got %0b want 0", t_extra); end
    checks++; if (t_hs1 != 3) begin errors++; $display("FAIL write_hs1_cycles: got %0d want 3", t_hs1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w2;
    sel = 1'b0; mapped = 1'b1; ack_d = 1; rel_d = 1; word = 32'h0000_0001;
    run_txn(1'b1, 8'h03, $urandom, 1'b0);
    checks++; if (t_lat != 5) begin errors++; $display("FAIL read_lat: got %0d want 5", t_lat); end
    checks++; if (t_rdata !== 32'h1) begin errors++; $display("FAIL read_rdata: got %08h want 1", t_rdata); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL read_err: got %0b want 0", t_err); end
    checks++; if (t_bus_bad !== 1'b0) begin errors++; $display("FAIL read_bus_hold: got %0b want 0", t_bus_bad); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b want 1", rdy); end
    w2 = $urandom; word = w2; ack_d = int'($urandom_range(0, 3)); rel_d = int'($urandom_range(0, 3));
    run_txn(1'b1, 8'($urandom), 32'h0, 1'b0);
    checks++; if (t_rdata !== w2) begin errors++; $display("FAIL b2b_rdata: got %08h want %08h", t_rdata, w2); end
    checks++;
    if (t_lat != ack_d + rel_d + 3) begin
      errors++; $display("FAIL b2b_lat: got %0d want %0d", t_lat, ack_d + rel_d + 3);
    end
  endtask

  task automatic test_long_release();
    logic [31:0] w;
    sel = 1'b0; mapped = 1'b1; ack_d = 1; rel_d = 40; w = $urandom; word = w;
    run_txn(1'b1, 8'h10, 32'h0, 1'b0);
    checks++; if (t_lat != 44) begin errors++; $display("FAIL long_release_lat: got %0d want 44", t_lat); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL long_release_err: got %0b want 0", t_err); end
    checks++; if (t_rdata !== w) begin errors++; $display("FAIL long_release_rdata: got %08h want %08h", t_rdata, w); end
  endtask

  task automatic test_cmd_hold();
    sel = 1'b0; mapped = 1'b1; ack_d = 3; rel_d = 2; word = $urandom;
    run_txn(1'b0, 8'h5A, 32'hCAFE_F00D, 1'b1);
    checks++; if (t_bus_bad !== 1'b0) begin errors++; $display("FAIL hold_bus: got %0b want 0", t_bus_bad); end
    checks++; if (t_rdy_bad !== 1'b0) begin errors++; $display("FAIL hold_ready: got %0b want 0", t_rdy_bad); end
    checks++; if (t_extra !== 1'b0) begin errors++; $display("FAIL hold_pulse: got %0b want 0", t_extra); end
    checks++; if (t_lat != 8) begin errors++; $display("FAIL hold_lat: got %0d want 8", t_lat); end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    sel = 1'b1; mapped = 1'b1; ack_d = 1; rel_d = 0; w = $urandom | 32'h1; word = w;
    run_txn(1'b1, 8'h04, 32'h0, 1'b0);
    checks++; if (t_rdata !== w) begin errors++; $display("FAIL pre_timeout_rdata: got %08h want %08h", t_rdata, w); end
    mapped = 1'b0;
    run_txn(1'b1, 8'h7F, 32'h0, 1'b0);
    checks++; if (t_hs1 != T_B) begin errors++; $display("FAIL timeout_hs1_cycles: got %0d want %0d", t_hs1, T_B); end
    checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %0b want 1", t_err); end
    checks++; if (t_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata: got %08h want 0", t_rdata); end
    checks++; if (t_lat != T_B + 1) begin errors++; $display("FAIL timeout_lat: got %0d want %0d", t_lat, T_B + 1); end
    checks++; if (hs1 !== 1'b0) begin errors++; $display("FAIL timeout_hs1_low: got %0b want 0", hs1); end
    mapped = 1'b1;
  endtask

  task automatic test_random();
    logic        rw, m;
    logic [7:0]  a;
    logic [31:0] wd, w, exp_rd;
    int          exp_lat, exp_hs1;
    sel = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom); a = 8'($urandom); wd = $urandom; w = $urandom;
      m = ($urandom_range(0, 7) != 0);
      ack_d = int'($urandom_range(0, 6)); rel_d = int'($urandom_range(0, 6));
      mapped = m; word = w;
      exp_rd  = (m && rw) ? w : 32'h0;
      exp_lat = m ? ack_d + rel_d + 3 : T_B + 1;
      exp_hs1 = m ? ack_d + 1 : T_B;
      run_txn(rw, a, wd, 1'b0);
      checks++;
      if (t_done !== 1'b1 || t_lat != exp_lat) begin
        errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, t_lat, exp_lat);
      end
      checks++;
      if (t_rdata !== exp_rd || t_err !== !m) begin
        errors++; $display("FAIL rand_rsp[%0d]: got %08h/%0b want %08h/%0b", n, t_rdata, t_err, exp_rd, !m);
      end
      checks++;
      if (t_hs1 != exp_hs1 || t_bus_bad !== 1'b0) begin
        errors++; $display("FAIL rand_bus[%0d]: got hs1=%0d bad=%0b want hs1=%0d bad=0", n, t_hs1, t_bus_bad, exp_hs1);
      end
    end
    mapped = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    sel = 1'b0; mapped = 1'b1; ack_d = 10; rel_d = 1; word = $urandom;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h22; cmd_wdata = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && hs1 !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++; if (hs1 !== 1'b1) begin errors++; $display("FAIL mid_reach_req: got %0b want 1", hs1); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({rdy, rv, err, hs1, brw} !== 5'b10000 || {addr_o, rd, dout} !== 72'h0) begin
      errors++; $display("FAIL mid_reset_values: got %05b %018h want 10000 0", {rdy, rv, err, hs1, brw}, {addr_o, rd, dout});
    end
    @(posedge clk); #1;
    checks++; if (rv !== 1'b0 || hs1 !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got rv=%0b hs1=%0b want 0 0", rv, hs1); end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL mid_after_release: got %0b want 0", rv); end
    ack_d = 1; rel_d = 1; w = $urandom; word = w;
    run_txn(1'b1, 8'h23, 32'h0, 1'b0);
    checks++;
    if (t_lat != 5 || t_rdata !== w || t_err !== 1'b0) begin
      errors++; $display("FAIL mid_recover: got lat=%0d %08h/%0b want lat=5 %08h/0", t_lat, t_rdata, t_err, w);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_long_release();
    test_cmd_hold();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_master_fsm.md
Name: bus_master_fsm

Overview:
- Initiator end of the IO_bus register protocol used by all subsystems (PWM channels and others).
- Accepts single register read/write commands from the host-side command decoder and drives reg_address, RW, data_out and handshake_1.
- Completes a 4-phase handshake against the addressed subsystem's handshake_2, captures data_in on reads, and returns one response per command.
- A timeout flags accesses to unmapped addresses or hung subsystems.

Parameters:
ADDR_WIDTH, 8, width of reg_address
DATA_WIDTH, 32, width of data_out/data_in
TIMEOUT_CYCLES, 255, max clk cycles waited for any handshake_2 edge (1..2^16-1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  host command present
cmd_ready  output  1  master can accept command (IDLE only)
cmd_rw  input  1  1 = read register, 0 = write register
cmd_addr  input  ADDR_WIDTH  target register address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/errors)
rsp_error  output  1  timeout occurred, valid with rsp_valid
bus_reg_address  output  ADDR_WIDTH  IO_bus reg_address
bus_RW  output  1  IO_bus RW (1 = read, 0 = write)
bus_data_out  output  DATA_WIDTH  IO_bus data_out (master to subsystem)
bus_data_in  input  DATA_WIDTH  IO_bus data_in (subsystem to master, Z when no subsystem drives)
bus_handshake_1  output  1  request strobe
bus_handshake_2  input  1  subsystem acknowledge

Behaviour:
- Reset (async, active-low): state IDLE; cmd_ready=1; rsp_valid=0, rsp_error=0, rsp_rdata=0; bus_reg_address=0, bus_RW=0, bus_data_out=0, bus_handshake_1=0; timeout counter=0.
- All bus signals are registered. handshake_2 is in the clk domain; no synchronizer.
- States: IDLE, SETUP, REQ, RELEASE, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_addr to bus_reg_address, cmd_rw to bus_RW, bus_data_out = cmd_rw ? 0 : cmd_wdata.
  - Go to SETUP.
- SETUP
  - Minimum 1 cycle; gives subsystem address decode setup.
  - Exit to REQ only when bus_handshake_2==0, and assert bus_handshake_1 on that edge.
  - If handshake_2 stays high for TIMEOUT_CYCLES: go to RESP with error.
- REQ (handshake_1=1)
  - Wait for handshake_2==1.
  - On the sampling edge: if read, capture bus_data_in into rsp_rdata. Deassert handshake_1. Go to RELEASE.
- RELEASE (handshake_1=0)
  - Wait for handshake_2==0, then go to RESP.
- RESP
  - rsp_valid=1 for exactly one cycle with rsp_error as set.
  - Return to IDLE.
  - rsp_rdata holds until the next response.
- Timeout counter
  - Cleared on every state entry; increments each cycle in SETUP/REQ/RELEASE.
  - On reaching TIMEOUT_CYCLES: force handshake_1=0, rsp_rdata=0, rsp_error=1, go to RESP.
- Write responses: rsp_rdata=0.
- Minimum transaction, subsystem acking after 1 cycle: accept edge to rsp_valid = 5 clk cycles.
- bus_reg_address/bus_RW/bus_data_out are held constant from SETUP through RESP; they keep their last values in IDLE.
- cmd_* are ignored while cmd_ready=0; no queuing.
- Reset mid-transaction: immediate return to reset values, handshake_1 dropped, no response issued.
- A stuck-high handshake_2 left over from an errored access blocks the next command in SETUP until it falls or times out.
- rsp_rdata captures exactly the sampled word, even if data_in is X/Z; unmapped reads surface as timeout.

Test Plan:
- Write 0x0000_03E8 to address 0x01, responder acks 2 cycles after handshake_1 rises and releases 1 cycle after it falls.
  -> Bus shows addr=0x01, RW=0, data_out=0x3E8 throughout.
  -> rsp_valid one cycle, rsp_error=0, rsp_rdata=0.
- Read address 0x03, responder drives 0x0000_0001 with ack.
  -> rsp_rdata=0x1, rsp_error=0, data_out=0 during access.
  -> Back-to-back second read accepted the cycle after RESP.
- Read unmapped address 0x7F, handshake_2 never rises, TIMEOUT_CYCLES=16.
  -> handshake_1 high exactly 16 cycles, then low.
  -> rsp_error=1, rsp_rdata=0.
- Responder holds handshake_2 high for 40 cycles after handshake_1 falls (TIMEOUT_CYCLES=255).
  -> Stays in RELEASE; response 1 cycle after handshake_2 falls; no error.
- cmd_valid held high with changing cmd_addr during a transaction.
  -> bus_reg_address unchanged; exactly one response per accepted command; cmd_ready low until IDLE.
- Assert reset while in REQ.
  -> Next cycle handshake_1=0, all outputs at reset values, no rsp_valid.
  -> A new command after reset completes normally.
